// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register and ALU operand-select stage.
// Captures the decoded instruction and resolves RAW hazards against the
// EX/MEM and MEM/WB writers. It stalls decode when needed and drives the
// ALU operands.
//
// Build option EX_FORWARD_EN:
//   defined   - bypass muxes forward exm/mwb results; a load-use hazard inserts one bubble.
//   undefined - no bypass; a dependency interlock stalls for up to 3
//               consecutive bubbles (the register file must write-first).
module ex_operand_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_AW     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_AW-1:0]     id_rs1,
    input  logic [REG_AW-1:0]     id_rs2,
    input  logic [DATA_WIDTH-1:0] id_rs1_data,
    input  logic [DATA_WIDTH-1:0] id_rs2_data,
    input  logic [DATA_WIDTH-1:0] id_imm,
    input  logic [DATA_WIDTH-1:0] id_pc,
    input  logic [3:0]            id_aluctrl,
    input  logic                  id_srca_pc,
    input  logic                  id_srcb_imm,
    input  logic [REG_AW-1:0]     id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  id_memwrite,
    input  logic                  flush,
    input  logic [REG_AW-1:0]     exm_rd,
    input  logic                  exm_regwrite,
    input  logic [DATA_WIDTH-1:0] exm_result,
    input  logic [REG_AW-1:0]     mwb_rd,
    input  logic                  mwb_regwrite,
    input  logic [DATA_WIDTH-1:0] mwb_result,
    output logic                  stall,
    output logic                  ex_valid,
    output logic [DATA_WIDTH-1:0] ALUop1,
    output logic [DATA_WIDTH-1:0] ALUop2,
    output logic [3:0]            ALUctrl,
    output logic [DATA_WIDTH-1:0] ex_store_data,
    output logic [REG_AW-1:0]     ex_rd,
    output logic                  ex_regwrite,
    output logic                  ex_memread,
    output logic                  ex_memwrite
);

    // Pipeline register state
    logic                  valid_q,     valid_d;
    logic [REG_AW-1:0]     rs1_q,       rs1_d;
    logic [REG_AW-1:0]     rs2_q,       rs2_d;
    logic [DATA_WIDTH-1:0] rs1_data_q,  rs1_data_d;
    logic [DATA_WIDTH-1:0] rs2_data_q,  rs2_data_d;
    logic [DATA_WIDTH-1:0] imm_q,       imm_d;
    logic [DATA_WIDTH-1:0] pc_q,        pc_d;
    logic [3:0]            aluctrl_q,   aluctrl_d;
    logic                  srca_pc_q,   srca_pc_d;
    logic                  srcb_imm_q,  srcb_imm_d;
    logic [REG_AW-1:0]     rd_q,        rd_d;
    logic                  regwrite_q,  regwrite_d;
    logic                  memread_q,   memread_d;
    logic                  memwrite_q,  memwrite_d;

    logic                  use_rs2_s;
    logic                  hazard_s;
    logic [DATA_WIDTH-1:0] fwd_rs1_s;
    logic [DATA_WIDTH-1:0] fwd_rs2_s;

`ifdef EX_FORWARD_EN
    // Bypass selection: x0 never matches and reads zero; EX/MEM beats MEM/WB.
    function automatic logic [DATA_WIDTH-1:0] fwd_operand(
        input logic [REG_AW-1:0]     rs,
        input logic [DATA_WIDTH-1:0] rf_data,
        input logic [REG_AW-1:0]     a_rd,
        input logic                  a_we,
        input logic [DATA_WIDTH-1:0] a_res,
        input logic [REG_AW-1:0]     b_rd,
        input logic                  b_we,
        input logic [DATA_WIDTH-1:0] b_res
    );
        logic [DATA_WIDTH-1:0] val;
        if (rs == '0) begin
            val = '0;
        end else if (a_we && (a_rd == rs)) begin
            val = a_res;
        end else if (b_we && (b_rd == rs)) begin
            val = b_res;
        end else begin
            val = rf_data;
        end
        return val;
    endfunction
`else
    logic [1:0] bub_cnt_q, bub_cnt_d;
    logic       unused_s;

    // True when a non-zero source register is still being produced by any in-flight writer.
    function automatic logic dep_hit(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] a_rd,
        input logic              a_we,
        input logic [REG_AW-1:0] b_rd,
        input logic              b_we,
        input logic [REG_AW-1:0] c_rd,
        input logic              c_we
    );
        return (rs != '0) && ((a_we && (a_rd == rs)) ||
                              (b_we && (b_rd == rs)) ||
                              (c_we && (c_rd == rs)));
    endfunction

    // The bypass results and registered source indices are not needed without forwarding.
    assign unused_s = ^{exm_result, mwb_result, rs1_q, rs2_q};
`endif

    // Hazard detection and the stall request sent back to decode.
    always_comb begin
        use_rs2_s = !id_srcb_imm || id_memwrite;
        hazard_s  = 1'b0;
`ifdef EX_FORWARD_EN
        if (id_valid && valid_q && memread_q && (rd_q != '0)) begin
            hazard_s = (rd_q == id_rs1) || ((rd_q == id_rs2) && use_rs2_s);
        end else begin
            hazard_s = 1'b0;
        end
`else
        if (id_valid && (bub_cnt_q != 2'd3)) begin
            hazard_s = dep_hit(id_rs1, rd_q, valid_q && regwrite_q,
                               exm_rd, exm_regwrite, mwb_rd, mwb_regwrite) ||
                       (use_rs2_s &&
                        dep_hit(id_rs2, rd_q, valid_q && regwrite_q,
                                exm_rd, exm_regwrite, mwb_rd, mwb_regwrite));
        end else begin
            hazard_s = 1'b0;
        end
`endif
        if (rst || flush) begin
            stall = 1'b0;
        end else begin
            stall = hazard_s;
        end
    end

    // Next-state of the pipeline register: flush or bubble kills, otherwise load decode.
    always_comb begin
        valid_d    = valid_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        pc_d       = pc_q;
        aluctrl_d  = aluctrl_q;
        srca_pc_d  = srca_pc_q;
        srcb_imm_d = srcb_imm_q;
        rd_d       = rd_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        if (flush || stall) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
        end else begin
            valid_d    = id_valid;
            rs1_d      = id_rs1;
            rs2_d      = id_rs2;
            rs1_data_d = id_rs1_data;
            rs2_data_d = id_rs2_data;
            imm_d      = id_imm;
            pc_d       = id_pc;
            aluctrl_d  = id_aluctrl;
            srca_pc_d  = id_srca_pc;
            srcb_imm_d = id_srcb_imm;
            rd_d       = id_rd;
            regwrite_d = id_regwrite;
            memread_d  = id_memread;
            memwrite_d = id_memwrite;
        end
    end

    // Pipeline register with synchronous reset clearing every field.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
            aluctrl_q  <= 4'h0;
            srca_pc_q  <= 1'b0;
            srcb_imm_q <= 1'b0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            pc_q       <= pc_d;
            aluctrl_q  <= aluctrl_d;
            srca_pc_q  <= srca_pc_d;
            srcb_imm_q <= srcb_imm_d;
            rd_q       <= rd_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
        end
    end

`ifndef EX_FORWARD_EN
    // Consecutive-bubble counter; caps an interlock at three bubbles.
    always_comb begin
        if (stall) begin
            bub_cnt_d = bub_cnt_q + 2'd1;
        end else begin
            bub_cnt_d = 2'd0;
        end
    end

    // Bubble counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            bub_cnt_q <= 2'd0;
        end else begin
            bub_cnt_q <= bub_cnt_d;
        end
    end
`endif

    // Operand bypass followed by the PC/immediate source-select muxes.
    always_comb begin
`ifdef EX_FORWARD_EN
        fwd_rs1_s = fwd_operand(rs1_q, rs1_data_q, exm_rd, exm_regwrite, exm_result,
                                mwb_rd, mwb_regwrite, mwb_result);
        fwd_rs2_s = fwd_operand(rs2_q, rs2_data_q, exm_rd, exm_regwrite, exm_result,
                                mwb_rd, mwb_regwrite, mwb_result);
`else
        fwd_rs1_s = rs1_data_q;
        fwd_rs2_s = rs2_data_q;
`endif
        if (srca_pc_q) begin
            ALUop1 = pc_q;
        end else begin
            ALUop1 = fwd_rs1_s;
        end
        if (srcb_imm_q) begin
            ALUop2 = imm_q;
        end else begin
            ALUop2 = fwd_rs2_s;
        end
        ex_store_data = fwd_rs2_s;
    end

    assign ex_valid    = valid_q;
    assign ALUctrl     = aluctrl_q;
    assign ex_rd       = rd_q;
    assign ex_regwrite = valid_q & regwrite_q;
    assign ex_memread  = valid_q & memread_q;
    assign ex_memwrite = valid_q & memwrite_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage (default parameters).
// Vector table plus scoreboard for single loads; hand-written sequences
// for reset, load-use/interlock, flush and rs2-use corner cases.
module tb_ex_operand_stage;

`ifdef EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, id_valid, id_srca_pc, id_srcb_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd, exm_rd, mwb_rd, ex_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
    logic [3:0]  id_aluctrl, ALUctrl;
    logic        id_regwrite, id_memread, id_memwrite, flush;
    logic        exm_regwrite, mwb_regwrite;
    logic [31:0] exm_result, mwb_result;
    logic        stall, ex_valid, ex_regwrite, ex_memread, ex_memwrite;
    logic [31:0] ALUop1, ALUop2, ex_store_data;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  ctrl;
        logic        srca;
        logic        srcb;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
    } instr_t;

    typedef struct packed {
        instr_t      ins;
        logic [4:0]  exm_rd;
        logic        exm_rw;
        logic [31:0] exm_res;
        logic [4:0]  mwb_rd;
        logic        mwb_rw;
        logic [31:0] mwb_res;
        logic [31:0] op1_f;
        logic [31:0] op2_f;
        logic [31:0] sd_f;
        logic [31:0] op1_n;
        logic [31:0] op2_n;
        logic [31:0] sd_n;
    } vec_t;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] sd;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
    } exp_t;

    vec_t   vecs [6];
    exp_t   sbq [$];
    exp_t   e;
    instr_t lw_x4, rd_x4;

    ex_operand_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_pc(id_pc), .id_aluctrl(id_aluctrl),
        .id_srca_pc(id_srca_pc), .id_srcb_imm(id_srcb_imm), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .flush(flush),
        .exm_rd(exm_rd), .exm_regwrite(exm_regwrite), .exm_result(exm_result),
        .mwb_rd(mwb_rd), .mwb_regwrite(mwb_regwrite), .mwb_result(mwb_result),
        .stall(stall), .ex_valid(ex_valid), .ALUop1(ALUop1), .ALUop2(ALUop2),
        .ALUctrl(ALUctrl), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input instr_t i);
        id_rs1      = i.rs1;
        id_rs2      = i.rs2;
        id_rs1_data = i.rs1d;
        id_rs2_data = i.rs2d;
        id_imm      = i.imm;
        id_pc       = i.pc;
        id_aluctrl  = i.ctrl;
        id_srca_pc  = i.srca;
        id_srcb_imm = i.srcb;
        id_rd       = i.rd;
        id_regwrite = i.rw;
        id_memread  = i.mr;
        id_memwrite = i.mw;
    endtask

    task automatic idle_cycle();
        id_valid     = 1'b0;
        flush        = 1'b0;
        exm_regwrite = 1'b0;
        mwb_regwrite = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Loads one instruction; returns 1 time unit after the loading edge.
    task automatic load(input instr_t i);
        drive(i);
        id_valid = 1'b1;
        @(posedge clk);
        #1;
        id_valid = 1'b0;
    endtask

    task automatic chk_bubble(input string nm);
        chk({nm, "_valid"},    32'(ex_valid),    32'd0);
        chk({nm, "_regwrite"}, 32'(ex_regwrite), 32'd0);
        chk({nm, "_memread"},  32'(ex_memread),  32'd0);
        chk({nm, "_memwrite"}, 32'(ex_memwrite), 32'd0);
    endtask

    initial begin
        //            rs1   rs2   rs1d          rs2d          imm           pc            ctrl  sa    sb    rd    rw    mr    mw
        vecs[0] = '{'{5'd1, 5'd2, 32'h1,        32'h2,        32'h0,        32'h100,      4'h0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0},
                    5'd1, 1'b1, 32'hAA, 5'd1, 1'b1, 32'hBB,
                    32'hAA, 32'h2, 32'h2, 32'h1, 32'h2, 32'h2};
        vecs[1] = '{'{5'd0, 5'd6, 32'h0,        32'h66,       32'h0,        32'h104,      4'h1, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0},
                    5'd0, 1'b1, 32'hFF, 5'd0, 1'b1, 32'hEE,
                    32'h0, 32'h66, 32'h66, 32'h0, 32'h66, 32'h66};
        vecs[2] = '{'{5'd7, 5'd8, 32'h70,       32'h80,       32'h0,        32'h108,      4'h2, 1'b0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0},
                    5'd9, 1'b1, 32'h99, 5'd8, 1'b1, 32'h88,
                    32'h70, 32'h88, 32'h88, 32'h70, 32'h80, 32'h80};
        vecs[3] = '{'{5'd10, 5'd11, 32'hA0,     32'hB0,       32'h0,        32'h10C,      4'h3, 1'b0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0},
                    5'd10, 1'b0, 32'h11, 5'd10, 1'b1, 32'h22,
                    32'h22, 32'hB0, 32'hB0, 32'hA0, 32'hB0, 32'hB0};
        vecs[4] = '{'{5'd13, 5'd2, 32'h300,     32'h5,        32'hFFFFF800, 32'h1000,     4'h0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1},
                    5'd2, 1'b1, 32'h55, 5'd13, 1'b1, 32'h77,
                    32'h1000, 32'hFFFFF800, 32'h55, 32'h1000, 32'hFFFFF800, 32'h5};
        vecs[5] = '{'{5'd14, 5'd15, 32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 32'h2000,   4'hF, 1'b0, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0},
                    5'd15, 1'b1, 32'h80000001, 5'd14, 1'b1, 32'h7FFFFFFF,
                    32'h7FFFFFFF, 32'h12345678, 32'h80000001, 32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D};

        lw_x4 = '{5'd3, 5'd0, 32'h200, 32'h0, 32'h10, 32'h40, 4'h0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0};
        rd_x4 = '{5'd4, 5'd4, 32'h0,   32'h0, 32'h0,  32'h44, 4'h0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0};

        // ---------------- reset ----------------
        drive('{5'd5, 5'd0, 32'h10, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0});
        rst = 1'b1; id_valid = 1'b1; flush = 1'b0;
        exm_rd = 5'd0; exm_regwrite = 1'b0; exm_result = 32'h0;
        mwb_rd = 5'd0; mwb_regwrite = 1'b0; mwb_result = 32'h0;
        #1;
        chk("rst_stall_pre", 32'(stall), 32'd0);
        @(posedge clk); #1;
        chk("rst_valid",    32'(ex_valid),    32'd0);
        chk("rst_op1",      ALUop1,           32'd0);
        chk("rst_op2",      ALUop2,           32'd0);
        chk("rst_ctrl",     32'(ALUctrl),     32'd0);
        chk("rst_sd",       ex_store_data,    32'd0);
        chk("rst_rd",       32'(ex_rd),       32'd0);
        chk("rst_ctlbits",  32'({ex_regwrite, ex_memread, ex_memwrite}), 32'd0);
        chk("rst_stall",    32'(stall),       32'd0);
        @(posedge clk); #1;
        chk("rst2_valid",   32'(ex_valid),    32'd0);
        chk("rst2_stall",   32'(stall),       32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_valid", 32'(ex_valid), 32'd1);
        chk("post_rst_op1",   ALUop1,        32'h10);
        chk("post_rst_rd",    32'(ex_rd),    32'd6);

        // ---------------- table-driven vectors with scoreboard ----------------
        for (int k = 0; k < 6; k++) begin
            idle_cycle();
            drive(vecs[k].ins);
            id_valid = 1'b1;
            e.op1  = FWD ? vecs[k].op1_f : vecs[k].op1_n;
            e.op2  = FWD ? vecs[k].op2_f : vecs[k].op2_n;
            e.sd   = FWD ? vecs[k].sd_f  : vecs[k].sd_n;
            e.ctrl = vecs[k].ins.ctrl;
            e.rd   = vecs[k].ins.rd;
            e.rw   = vecs[k].ins.rw;
            e.mr   = vecs[k].ins.mr;
            e.mw   = vecs[k].ins.mw;
            sbq.push_back(e);
            #1;
            chk($sformatf("v%0d_stall", k), 32'(stall), 32'd0);
            @(posedge clk); #1;
            id_valid     = 1'b0;
            exm_rd       = vecs[k].exm_rd;
            exm_regwrite = vecs[k].exm_rw;
            exm_result   = vecs[k].exm_res;
            mwb_rd       = vecs[k].mwb_rd;
            mwb_regwrite = vecs[k].mwb_rw;
            mwb_result   = vecs[k].mwb_res;
            #1;
            chk($sformatf("v%0d_sb_depth", k), 32'(sbq.size()), 32'd1);
            e = sbq.pop_front();
            chk($sformatf("v%0d_valid", k), 32'(ex_valid),      32'd1);
            chk($sformatf("v%0d_op1", k),   ALUop1,             e.op1);
            chk($sformatf("v%0d_op2", k),   ALUop2,             e.op2);
            chk($sformatf("v%0d_sd", k),    ex_store_data,      e.sd);
            chk($sformatf("v%0d_ctrl", k),  32'(ALUctrl),       32'(e.ctrl));
            chk($sformatf("v%0d_rd", k),    32'(ex_rd),         32'(e.rd));
            chk($sformatf("v%0d_bits", k),  32'({ex_regwrite, ex_memread, ex_memwrite}),
                                            32'({e.rw, e.mr, e.mw}));
        end

        // ---------------- load-use / interlock ----------------
`ifdef EX_FORWARD_EN
        idle_cycle();
        load(lw_x4);
        drive(rd_x4); id_valid = 1'b1;
        #1;
        chk("lu_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        chk_bubble("lu_bubble");
        chk("lu_stall_drop", 32'(stall), 32'd0);
        exm_rd = 5'd4; exm_regwrite = 1'b1; exm_result = 32'h1234;
        @(posedge clk); #1;
        id_valid = 1'b0;
        #1;
        chk("lu_add_valid", 32'(ex_valid), 32'd1);
        chk("lu_add_op1",   ALUop1,        32'h1234);
        chk("lu_add_op2",   ALUop2,        32'h1234);
        chk("lu_add_rd",    32'(ex_rd),    32'd5);
`else
        idle_cycle();
        load('{5'd1, 5'd0, 32'h5, 32'h0, 32'h3, 32'h50, 4'h0, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0});
        drive('{5'd7, 5'd0, 32'h8, 32'h0, 32'h1, 32'h54, 4'h0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0});
        id_valid = 1'b1;
        #1;
        chk("il_stall1", 32'(stall), 32'd1);
        @(posedge clk); #1;
        exm_rd = 5'd7; exm_regwrite = 1'b1;
        #1;
        chk("il_stall2", 32'(stall), 32'd1);
        chk_bubble("il_bub1");
        @(posedge clk); #1;
        exm_regwrite = 1'b0; mwb_rd = 5'd7; mwb_regwrite = 1'b1;
        #1;
        chk("il_stall3", 32'(stall), 32'd1);
        chk_bubble("il_bub2");
        @(posedge clk); #1;
        mwb_regwrite = 1'b0;
        #1;
        chk("il_stall_end", 32'(stall), 32'd0);
        chk_bubble("il_bub3");
        @(posedge clk); #1;
        id_valid = 1'b0;
        chk("il_rd_valid", 32'(ex_valid), 32'd1);
        chk("il_rd_op1",   ALUop1,        32'h8);
        chk("il_rd_rd",    32'(ex_rd),    32'd8);
`endif

        // ---------------- flush beats hazard ----------------
        idle_cycle();
        load(lw_x4);
        drive(rd_x4); id_valid = 1'b1; flush = 1'b1;
        #1;
        chk("fl_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; id_valid = 1'b0;
        chk_bubble("fl_next");

        // ---------------- rs2 use condition ----------------
        idle_cycle();
        load(lw_x4);
        drive('{5'd1, 5'd4, 32'h0, 32'h0, 32'h8, 32'h60, 4'h0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0});
        id_valid = 1'b1;
        #1;
        chk("rs2_imm_nostall", 32'(stall), 32'd1 - 32'd1);
        id_memwrite = 1'b1; id_regwrite = 1'b0;
        #1;
        chk("rs2_store_stall", 32'(stall), 32'd1);
        id_memwrite = 1'b0; id_srcb_imm = 1'b0;
        #1;
        chk("rs2_reg_stall", 32'(stall), 32'd1);
        id_valid = 1'b0;
        #1;
        chk("rs2_novalid", 32'(stall), 32'd0);

        // ---------------- held load to x0 never stalls ----------------
        idle_cycle();
        load('{5'd3, 5'd0, 32'h0, 32'h0, 32'h0, 32'h70, 4'h0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0});
        drive('{5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h74, 4'h0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0});
        id_valid = 1'b1;
        #1;
        chk("x0_nostall", 32'(stall), 32'd0);

        // ---------------- reset mid-stall ----------------
        idle_cycle();
        load(lw_x4);
        drive(rd_x4); id_valid = 1'b1;
        #1;
        chk("rms_stall", 32'(stall), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rms_stall_drop", 32'(stall), 32'd0);
        chk("rms_valid",      32'(ex_valid), 32'd0);
        id_valid = 1'b0;
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
